// File: rtl/uib_arbiter_pkg.sv
// Shared bus package for the uib arbiter: default parameter constants and
// FSM state encoding used by uib_arbiter and uib_rr_pick.
package uib_arbiter_pkg;

  // Default build-time sizes for the uib bus-master port
  localparam int UIB_MASTER_SIZE = 2;
  localparam int UIB_XLEN        = 32;
  localparam int UIB_SLAVE_WIDTH = 4;
  localparam int UIB_TIMEOUT     = 255;

  // Arbiter FSM state encoding
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_BUSY = 2'd1;
  localparam arb_state_t ST_DONE = 2'd2;

  // Index width for a master number; at least one bit even for tiny configs
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uib_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after `last`, wrapping.
// Purely combinational; output is one-hot, or zero when nothing requests.
module uib_rr_pick
  import uib_arbiter_pkg::*;
#(
  parameter int N   = UIB_MASTER_SIZE,
  parameter int LGW = idx_w(N)
)(
  input  logic [N-1:0]   req,
  input  logic [LGW-1:0] last,
  output logic [N-1:0]   pick
);

  // Walk last+1 .. last+N (mod N) and take the first active request
  always_comb begin
    logic           found;
    logic [LGW-1:0] sel;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      sel = LGW'((int'(last) + k) % N);
      if (!found && req[sel]) begin
        pick[sel] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uib_arbiter.sv
// uib_arbiter: shares one uib bus-master port between MASTER_SIZE masters.
// IDLE -> BUSY (owner drives the bus) -> DONE (one dead cycle) -> IDLE.
// Optional watchdog enabled by defining UIB_ARB_TIMEOUT_EN: a stalled
// transaction is aborted with m_err=1 after TIMEOUT cycles without bus_ready.
module uib_arbiter
  import uib_arbiter_pkg::*;
#(
  parameter int MASTER_SIZE = UIB_MASTER_SIZE,
  parameter int XLEN        = UIB_XLEN,
  parameter int SLAVE_WIDTH = UIB_SLAVE_WIDTH,
  parameter int TIMEOUT     = UIB_TIMEOUT
)(
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [MASTER_SIZE-1:0]                            m_req,
  input  logic [MASTER_SIZE-1:0]                            m_wen,
  input  logic [MASTER_SIZE-1:0][XLEN-SLAVE_WIDTH-1:0]      m_addr,
  input  logic [MASTER_SIZE-1:0][SLAVE_WIDTH-1:0]           m_num,
  input  logic [MASTER_SIZE-1:0][2:0]                       m_mode,
  input  logic [MASTER_SIZE-1:0][XLEN-1:0]                  m_dat_o,
  output logic [MASTER_SIZE-1:0]                            m_ready,
  output logic                                              m_err,
  output logic [XLEN-1:0]                                   m_dat_i,
  output logic                                              bus_req,
  output logic                                              bus_wen,
  output logic [XLEN-SLAVE_WIDTH-1:0]                       bus_addr,
  output logic [SLAVE_WIDTH-1:0]                            bus_num,
  output logic [2:0]                                        bus_mode,
  output logic [XLEN-1:0]                                   bus_dat_o,
  input  logic                                              bus_ready,
  input  logic [XLEN-1:0]                                   bus_dat_i,
  output logic [MASTER_SIZE-1:0]                            grant
);

  localparam int LGW = idx_w(MASTER_SIZE);

  arb_state_t             state;
  logic [MASTER_SIZE-1:0] grant_q;
  logic [MASTER_SIZE-1:0] pick;
  logic [LGW-1:0]         last_grant;
  logic [LGW-1:0]         grant_idx;
  logic                   busy;
  logic                   wdog_hit;
  logic                   done;

  uib_rr_pick #(.N(MASTER_SIZE), .LGW(LGW)) u_pick (
    .req  (m_req),
    .last (last_grant),
    .pick (pick)
  );

  assign busy = (state == ST_BUSY);

`ifdef UIB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);
  logic [7:0] wdog;

  // Watchdog: zero while idle so it starts at 0 on BUSY entry, counts stalls
  always_ff @(posedge clk) begin
    if (!rst)                                       wdog <= '0;
    else if (state == ST_IDLE)                      wdog <= '0;
    else if (busy && !bus_ready && wdog != TO_LIM)  wdog <= wdog + 8'd1;
  end

  // A real completion in the same cycle wins over the abort
  assign wdog_hit = busy && !bus_ready && (wdog == TO_LIM);
`else
  assign wdog_hit = 1'b0;
`endif

  assign done    = busy && (bus_ready || wdog_hit);
  assign bus_req = busy;
  assign grant   = grant_q;
  assign m_ready = done ? grant_q : '0;
  assign m_err   = wdog_hit;
  assign m_dat_i = (busy && bus_ready) ? bus_dat_i : '0;

  // Bus field mux from the registered grant; all zero outside BUSY
  always_comb begin
    bus_wen   = 1'b0;
    bus_addr  = '0;
    bus_num   = '0;
    bus_mode  = '0;
    bus_dat_o = '0;
    grant_idx = '0;
    for (int i = 0; i < MASTER_SIZE; i++) begin
      if (grant_q[i]) grant_idx = LGW'(i);
      if (busy && grant_q[i]) begin
        bus_wen   = m_wen[i];
        bus_addr  = m_addr[i];
        bus_num   = m_num[i];
        bus_mode  = m_mode[i];
        bus_dat_o = m_dat_o[i];
      end
    end
  end

  // Arbitration FSM; last_grant resets to the top master so master 0 wins first
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      last_grant <= LGW'(MASTER_SIZE - 1);
    end else begin
      case (state)
        ST_IDLE: if (|m_req) begin
          grant_q <= pick;
          state   <= ST_BUSY;
        end
        ST_BUSY: if (done) begin
          last_grant <= grant_idx;
          grant_q    <= '0;
          state      <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: begin
          grant_q <= '0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uib_arbiter.sv
// Testbench for uib_arbiter: directed scenarios plus randomized traffic, all
// checked cycle-by-cycle against a transaction-level reference model.
// Honors UIB_ARB_TIMEOUT_EN the same way the design does.
module tb_uib_arbiter;

  localparam int M  = 3;
  localparam int XL = 32;
  localparam int SW = 4;
  localparam int AW = XL - SW;
  localparam int TO = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [M-1:0]           m_req, m_wen;
  logic [M-1:0][AW-1:0]   m_addr;
  logic [M-1:0][SW-1:0]   m_num;
  logic [M-1:0][2:0]      m_mode;
  logic [M-1:0][XL-1:0]   m_dat_o;
  logic [M-1:0]           m_ready;
  logic                   m_err;
  logic [XL-1:0]          m_dat_i;
  logic                   bus_req, bus_wen;
  logic [AW-1:0]          bus_addr;
  logic [SW-1:0]          bus_num;
  logic [2:0]             bus_mode;
  logic [XL-1:0]          bus_dat_o;
  logic                   bus_ready;
  logic [XL-1:0]          bus_dat_i;
  logic [M-1:0]           grant;

  uib_arbiter #(.MASTER_SIZE(M), .XLEN(XL), .SLAVE_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr),
    .m_num(m_num), .m_mode(m_mode), .m_dat_o(m_dat_o), .m_ready(m_ready),
    .m_err(m_err), .m_dat_i(m_dat_i), .bus_req(bus_req), .bus_wen(bus_wen),
    .bus_addr(bus_addr), .bus_num(bus_num), .bus_mode(bus_mode),
    .bus_dat_o(bus_dat_o), .bus_ready(bus_ready), .bus_dat_i(bus_dat_i),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner index (-1 = none), dead cycles pending, last owner,
  // stalled cycles of the current owner
  int own, gap, last, stall;

  // Snapshot of outputs taken at the checking edge of the last tick
  logic [M-1:0]  obs_grant, obs_ready;
  logic          obs_err, obs_bus_req;
  logic [AW-1:0] obs_addr;
  logic [SW-1:0] obs_num;
  logic [XL-1:0] obs_dat_o, obs_dat_i;
  logic          obs_wen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rnd_fields();
    for (int i = 0; i < M; i++) begin
      m_wen[i]   = 1'($urandom);
      m_addr[i]  = AW'($urandom);
      m_num[i]   = SW'($urandom);
      m_mode[i]  = 3'($urandom);
      m_dat_o[i] = $urandom;
    end
    bus_dat_i = $urandom;
  endtask

  // One clock: check outputs against the model at negedge, advance the model,
  // then return just after the following posedge so callers can drive inputs
  task automatic tick();
    logic          to_hit;
    logic [M-1:0]  e_ready, e_grant;
    logic          e_wen;
    logic [AW-1:0] e_addr;
    logic [SW-1:0] e_num;
    logic [2:0]    e_mode;
    logic [XL-1:0] e_dat_o, e_dat_i;
    @(negedge clk);
    obs_grant = grant;   obs_ready = m_ready; obs_err = m_err;
    obs_bus_req = bus_req; obs_addr = bus_addr; obs_num = bus_num;
    obs_dat_o = bus_dat_o; obs_dat_i = m_dat_i; obs_wen = bus_wen;
`ifdef UIB_ARB_TIMEOUT_EN
    to_hit = (own >= 0) && !bus_ready && (stall == TO);
`else
    to_hit = 1'b0;
`endif
    e_ready = '0; e_grant = '0; e_wen = 1'b0; e_addr = '0; e_num = '0;
    e_mode = '0; e_dat_o = '0; e_dat_i = '0;
    if (own >= 0) begin
      e_grant[own] = 1'b1;
      e_wen   = m_wen[own];
      e_addr  = m_addr[own];
      e_num   = m_num[own];
      e_mode  = m_mode[own];
      e_dat_o = m_dat_o[own];
      if (bus_ready || to_hit) e_ready[own] = 1'b1;
      if (bus_ready) e_dat_i = bus_dat_i;
    end
    chk("grant",     64'(grant),     64'(e_grant));
    chk("bus_req",   64'(bus_req),   64'(own >= 0));
    chk("bus_wen",   64'(bus_wen),   64'(e_wen));
    chk("bus_addr",  64'(bus_addr),  64'(e_addr));
    chk("bus_num",   64'(bus_num),   64'(e_num));
    chk("bus_mode",  64'(bus_mode),  64'(e_mode));
    chk("bus_dat_o", 64'(bus_dat_o), 64'(e_dat_o));
    chk("m_ready",   64'(m_ready),   64'(e_ready));
    chk("m_err",     64'(m_err),     64'(to_hit));
    chk("m_dat_i",   64'(m_dat_i),   64'(e_dat_i));
    if (!rst) begin
      own = -1; gap = 0; last = M - 1; stall = 0;
    end else if (own >= 0) begin
      if (bus_ready || to_hit) begin
        last = own; own = -1; gap = 1;
      end else stall++;
    end else if (gap > 0) begin
      gap = 0;
    end else if (m_req != '0) begin
      for (int k = 1; k <= M; k++) begin
        int j;
        j = (last + k) % M;
        if (m_req[j] && own < 0) own = j;
      end
      stall = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(); rst = 1'b1;
  endtask

  initial begin
    logic [M-1:0] gseq [4];
    logic [M-1:0] exp_seq [4];
    int ng, ent, lat;
    logic found, any_rdy, all_req;

    own = -1; gap = 0; last = M - 1; stall = 0;
    rst = 1'b0; m_req = '0; bus_ready = 1'b0;
    rnd_fields();
    @(posedge clk); #1;
    do_reset();
    chk("rst_grant", 64'(obs_grant), 64'd0);

    // Single read by master 0, two wait cycles, then completion
    m_req = 3'b001; m_wen[0] = 1'b0;
    tick(); tick(); tick();
    bus_ready = 1'b1; bus_dat_i = 32'hDEADBEEF;
    tick();
    chk("single_rdy",   64'(obs_ready), 64'd1);
    chk("single_dat",   64'(obs_dat_i), 64'hDEADBEEF);
    chk("single_grant", 64'(obs_grant), 64'd1);
    m_req = '0; bus_ready = 1'b0;
    tick();
    chk("single_done_grant", 64'(obs_grant), 64'd0);
    chk("single_done_rdy",   64'(obs_ready), 64'd0);
    tick();

    // Contention: two masters requesting continuously alternate
    do_reset();
    m_req = 3'b011; bus_ready = 1'b1;
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b001; exp_seq[3] = 3'b010;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      rnd_fields(); tick();
      if (obs_ready != '0) begin gseq[ng] = obs_grant; ng++; end
    end
    chk("cont_count", 64'(ng), 64'd4);
    for (int i = 0; i < ng; i++) chk("cont_seq", 64'(gseq[i]), 64'(exp_seq[i]));
    m_req = '0; bus_ready = 1'b0;
    tick(); tick();

    // Field mux: master 1 write, master 0 fields differ and are not selected
    rnd_fields();
    m_req = 3'b010; m_wen[1] = 1'b1; m_addr[1] = 28'h0000100;
    m_num[1] = 4'h2; m_dat_o[1] = 32'h12345678;
    m_wen[0] = 1'b0; m_addr[0] = 28'hFFFFFFF; m_num[0] = 4'hF; m_dat_o[0] = 32'hA5A5A5A5;
    tick(); tick();
    chk("mux_grant", 64'(obs_grant), 64'b010);
    chk("mux_wen",   64'(obs_wen),   64'd1);
    chk("mux_addr",  64'(obs_addr),  64'h0000100);
    chk("mux_num",   64'(obs_num),   64'h2);
    chk("mux_dat",   64'(obs_dat_o), 64'h12345678);
    bus_ready = 1'b1; tick();
    m_req = 3'b001; tick(); tick(); tick();   // master 0 completes, last = 0
    bus_ready = 1'b0; m_req = '0; tick(); tick();

    // Reset while master 1 owns the bus
    m_req = 3'b011; tick(); tick();
    chk("rbusy_grant", 64'(obs_grant), 64'b010);
    rst = 1'b0; tick(); rst = 1'b1;
    tick();
    chk("rbusy_zero", 64'({obs_grant, obs_ready, obs_bus_req, obs_addr, obs_dat_i}), 64'd0);
    tick();
    chk("rbusy_first", 64'(obs_grant), 64'b001);
    bus_ready = 1'b1; tick(); m_req = '0; bus_ready = 1'b0; tick(); tick();

`ifdef UIB_ARB_TIMEOUT_EN
    // Watchdog abort after TO stalled cycles, then the other master proceeds
    m_req = 3'b001; ent = -1; lat = -1; found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      tick();
      if (obs_bus_req && ent < 0) ent = c;
      if (obs_ready != '0) begin found = 1'b1; lat = c - ent; end
    end
    chk("to_seen", 64'(found), 64'd1);
    chk("to_lat",  64'(lat),   64'(TO));
    chk("to_err",  64'(obs_err), 64'd1);
    chk("to_dat",  64'(obs_dat_i), 64'd0);
    m_req = 3'b011; tick(); tick(); tick();
    chk("to_next", 64'(obs_grant), 64'b010);
    bus_ready = 1'b1; tick(); m_req = '0; bus_ready = 1'b0; tick(); tick();
`else
    // Without the watchdog a stalled transaction waits indefinitely
    m_req = 3'b001; any_rdy = 1'b0; all_req = 1'b1;
    tick();
    for (int c = 0; c < 1000; c++) begin
      tick();
      any_rdy = any_rdy | (|obs_ready) | obs_err;
      all_req = all_req & obs_bus_req;
    end
    chk("stall_req", 64'(all_req), 64'd1);
    chk("stall_rdy", 64'(any_rdy), 64'd0);
    do_reset(); m_req = '0;
`endif

    // Randomized traffic, occasional resets
    for (int c = 0; c < 600; c++) begin
      rnd_fields();
      m_req     = M'($urandom);
      bus_ready = ($urandom_range(0, 2) == 0);
      rst       = ($urandom_range(0, 60) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
